// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-frame instruction cache with a
// two-state IDLE/FETCH fill controller.
// Optional fetch statistics are enabled by defining ICACHE_STATS_EN;
// without it, hit_count and miss_count read constant zero.
module icache #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int INDEX_W = $clog2(SETS);
   localparam int TAG_W   = 32 - 2 - INDEX_W;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t state_q, state_d;

   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [31:0]      data_q [SETS];

   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   addrTag;
   logic               fillEn;
   logic               unusedOffset;

   // The byte offset never selects anything since every frame holds one word.
   assign unusedOffset = ^imemaddr[1:0];

   assign index   = imemaddr[2 +: INDEX_W];
   assign addrTag = imemaddr[31 -: TAG_W];

   // A fill only completes when the datapath still wants the word and memory has it.
   assign fillEn = (state_q == FETCH) && imemREN && !iwait;

   // Hit detection and data return; hits are only reported while idle.
   always_comb begin
      ihit     = 1'b0;
      imemload = 32'h0;
      if ((state_q == IDLE) && imemREN && valid_q[index] && (tag_q[index] == addrTag)) begin
         ihit     = 1'b1;
         imemload = data_q[index];
      end
   end

   // Next-state logic and memory-side request outputs.
   always_comb begin
      state_d = state_q;
      iREN    = 1'b0;
      iaddr   = 32'h0;
      unique case (state_q)
         IDLE: begin
            if (imemREN && !ihit) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            iREN  = 1'b1;
            iaddr = {imemaddr[31:2], 2'b00};
            if (!imemREN || !iwait) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; a reset mid-fill drops straight back to IDLE.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Valid bits are the only per-frame state cleared by reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q <= '0;
      end else if (fillEn) begin
         valid_q[index] <= 1'b1;
      end
   end

   // Tag and data storage is left uninitialised; the valid bit guards it.
   always_ff @(posedge CLK) begin
      if (fillEn) begin
         tag_q[index]  <= addrTag;
         data_q[index] <= iload;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hitCnt_q, hitCnt_d;
   logic [31:0] missCnt_q, missCnt_d;

   // Saturating counters: hits per ihit cycle, misses per IDLE->FETCH move.
   always_comb begin
      hitCnt_d  = hitCnt_q;
      missCnt_d = missCnt_q;
      if (ihit && (hitCnt_q != 32'hFFFF_FFFF)) begin
         hitCnt_d = hitCnt_q + 32'd1;
      end
      if ((state_q == IDLE) && (state_d == FETCH) && (missCnt_q != 32'hFFFF_FFFF)) begin
         missCnt_d = missCnt_q + 32'd1;
      end
   end

   // Statistic registers cleared by reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hitCnt_q  <= 32'h0;
         missCnt_q <= 32'h0;
      end else begin
         hitCnt_q  <= hitCnt_d;
         missCnt_q <= missCnt_d;
      end
   end

   assign hit_count  = hitCnt_q;
   assign miss_count = missCnt_q;
`else
   assign hit_count  = 32'h0;
   assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed-vector bench for icache with SETS=16.
// Statistic expectations follow whether ICACHE_STATS_EN is defined.
module tb_icache;

`ifdef ICACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        CLK;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int vectorsApplied = 0;
   int miscompares    = 0;
   int renCycles;

   icache #(.SETS(16)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .imemREN    (imemREN),
      .imemaddr   (imemaddr),
      .ihit       (ihit),
      .imemload   (imemload),
      .iREN       (iREN),
      .iaddr      (iaddr),
      .iwait      (iwait),
      .iload      (iload),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   // Free-running 10 ns clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Compares one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorsApplied++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drives the datapath and memory-side inputs, then lets combinational outputs settle.
   task automatic applyStimulus(input logic ren, input logic [31:0] addr, input logic w, input logic [31:0] load);
      imemREN  = ren;
      imemaddr = addr;
      iwait    = w;
      iload    = load;
      #1;
   endtask

   // Advances one clock and leaves the bench just past the rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] expStat(input int n);
      return STATS ? 32'(n) : 32'h0;
   endfunction

   initial begin
      nRST = 1'b0;
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
      step();
      checkOutput("rst_ihit", {31'b0, ihit}, 32'd0);
      checkOutput("rst_imemload", imemload, 32'h0);
      checkOutput("rst_iREN", {31'b0, iREN}, 32'd0);
      checkOutput("rst_iaddr", iaddr, 32'h0);
      checkOutput("rst_hits", hit_count, 32'h0);
      checkOutput("rst_misses", miss_count, 32'h0);

      // Cold miss on 0x40: three wait cycles with junk on iload, then the fill.
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
      nRST = 1'b1;
      step();
      applyStimulus(1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF);
      checkOutput("cold_nohit", {31'b0, ihit}, 32'd0);
      renCycles = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 3) applyStimulus(1'b1, 32'h40, 1'b0, 32'h8C22_0004);
         else        applyStimulus(1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF);
         if (iREN) renCycles++;
         if (i == 0) checkOutput("cold_iaddr", iaddr, 32'h40);
         if (i == 3) checkOutput("cold_fill_nohit", {31'b0, ihit}, 32'd0);
      end
      step();
      checkOutput("cold_ren_cycles", 32'(renCycles), 32'd4);
      checkOutput("cold_hit", {31'b0, ihit}, 32'd1);
      checkOutput("cold_data", imemload, 32'h8C22_0004);
      checkOutput("cold_ren_off", {31'b0, iREN}, 32'd0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
      step();

      // Repeat hit on 0x40 in a single idle cycle.
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
      checkOutput("repeat_hit", {31'b0, ihit}, 32'd1);
      checkOutput("repeat_data", imemload, 32'h8C22_0004);
      checkOutput("repeat_iREN", {31'b0, iREN}, 32'd0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
      checkOutput("stats_hits", hit_count, expStat(2));
      checkOutput("stats_misses", miss_count, expStat(1));

      // Conflict miss: 0x440 shares index 0 with 0x40.
      applyStimulus(1'b1, 32'h440, 1'b1, 32'h0);
      checkOutput("conf_nohit", {31'b0, ihit}, 32'd0);
      step();
      applyStimulus(1'b1, 32'h440, 1'b0, 32'h1111_1111);
      checkOutput("conf_iREN", {31'b0, iREN}, 32'd1);
      checkOutput("conf_iaddr", iaddr, 32'h440);
      step();
      checkOutput("conf_hit", {31'b0, ihit}, 32'd1);
      checkOutput("conf_data", imemload, 32'h1111_1111);
      step();
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
      checkOutput("conf_evicted", {31'b0, ihit}, 32'd0);
      step();
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h8C22_0004);
      checkOutput("refill_iaddr", iaddr, 32'h40);
      step();
      checkOutput("refill_hit", {31'b0, ihit}, 32'd1);
      step();
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
      checkOutput("conf_stat_hits", hit_count, expStat(4));
      checkOutput("conf_stat_misses", miss_count, expStat(3));

      // Abandoned fill on 0x80.
      applyStimulus(1'b1, 32'h80, 1'b1, 32'h0);
      step();
      checkOutput("aband_iaddr", iaddr, 32'h80);
      applyStimulus(1'b0, 32'h80, 1'b1, 32'h2222_2222);
      step();
      checkOutput("aband_idle", {31'b0, iREN}, 32'd0);
      applyStimulus(1'b1, 32'h80, 1'b1, 32'h0);
      checkOutput("aband_remiss", {31'b0, ihit}, 32'd0);
      step();
      checkOutput("aband_refetch", {31'b0, iREN}, 32'd1);

      // Reset while a fill is outstanding.
      nRST = 1'b0;
      #1;
      checkOutput("midrst_iREN", {31'b0, iREN}, 32'd0);
      checkOutput("midrst_iaddr", iaddr, 32'h0);
      checkOutput("midrst_misses", miss_count, 32'h0);
      step();
      nRST = 1'b1;
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
      checkOutput("postrst_miss", {31'b0, ihit}, 32'd0);
      step();
      checkOutput("postrst_fetch", {31'b0, iREN}, 32'd1);

      // Address changes mid-fill: the frame indexed at the fill cycle is written.
      applyStimulus(1'b1, 32'h104, 1'b0, 32'h3333_3333);
      checkOutput("move_iaddr", iaddr, 32'h104);
      step();
      checkOutput("move_hit", {31'b0, ihit}, 32'd1);
      checkOutput("move_data", imemload, 32'h3333_3333);
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
      checkOutput("move_old_miss", {31'b0, ihit}, 32'd0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
